// File: rtl/ascon_perm_msk.sv
// ascon_perm_msk: d-share masked Ascon-p[r] permutation, two cycles per round.
// RA registers the HPC2 gadget terms; RB finishes the S-box and diffusion.
module ascon_perm_msk #(
    parameter int d    = 2,
    parameter int NRND = 320 * d * (d - 1) / 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       round_sel,
    input  logic [320*d-1:0] in,
    input  logic [NRND-1:0]  rnd,
    input  logic             rnd_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [320*d-1:0] out,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RA, RB, DONE} state_t;

    function automatic int pair_idx(int i, int j);
        return i * d - i * (i + 1) / 2 + (j - i - 1);
    endfunction

    function automatic logic [63:0] ror(logic [63:0] w, int n);
        return (w >> n) | (w << (64 - n));
    endfunction

    function automatic logic [63:0] diffuse(logic [63:0] w, int k);
        logic [63:0] r;
        case (k)
            0:       r = w ^ ror(w, 19) ^ ror(w, 28);
            1:       r = w ^ ror(w, 61) ^ ror(w, 39);
            2:       r = w ^ ror(w, 1) ^ ror(w, 6);
            3:       r = w ^ ror(w, 10) ^ ror(w, 17);
            default: r = w ^ ror(w, 7) ^ ror(w, 41);
        endcase
        return r;
    endfunction

    state_t state_q, state_d;
    logic [d-1:0][319:0] st_q, st_d;
    logic [3:0] idx_q, idx_d;
    logic [d-1:0][d-1:0][4:0][63:0] s_q, s_d;
    logic [d-1:0][d-1:0][4:0][63:0] u_q, u_d;
    logic out_valid_q, out_valid_d;
    logic in_ready_q, in_ready_d;
    logic busy_q, busy_d;

    logic [7:0] rc;
    logic [63:0] rw;
    logic [d-1:0][4:0][63:0] xw, yw, aw, bw, tw, zw;
    logic [d-1:0][319:0] nst;

    // S-box input layer, recomputed identically in RA and RB
    always_comb begin
        xw = '0;
        yw = '0;
        aw = '0;
        bw = '0;
        rc = 8'hF0 - 8'h0F * {4'd0, idx_q};
        for (int s = 0; s < d; s++) begin
            for (int k = 0; k < 5; k++) begin
                xw[s][k] = st_q[s][(4-k)*64 +: 64];
            end
            if (s == 0) begin
                xw[s][2][7:0] = xw[s][2][7:0] ^ rc;
            end
            yw[s][0] = xw[s][0] ^ xw[s][4];
            yw[s][1] = xw[s][1];
            yw[s][2] = xw[s][2] ^ xw[s][1];
            yw[s][3] = xw[s][3];
            yw[s][4] = xw[s][4] ^ xw[s][3];
            for (int k = 0; k < 5; k++) begin
                aw[s][k] = (s == 0) ? ~yw[s][k] : yw[s][k];
                bw[s][k] = yw[s][(k+1)%5];
            end
        end
    end

    // HPC2 first stage: diagonal keeps b_i, off-diagonal gets b_j^r and ~a_i&r
    always_comb begin
        s_d = s_q;
        u_d = u_q;
        rw  = '0;
        if (state_q == RA && rnd_valid) begin
            for (int i = 0; i < d; i++) begin
                for (int j = 0; j < d; j++) begin
                    for (int k = 0; k < 5; k++) begin
                        if (i == j) begin
                            s_d[i][j][k] = bw[i][k];
                            u_d[i][j][k] = '0;
                        end else begin
                            rw = rnd[((i < j) ? pair_idx(i, j) : pair_idx(j, i)) * 320
                                     + k * 64 +: 64];
                            s_d[i][j][k] = bw[j][k] ^ rw;
                            u_d[i][j][k] = ~aw[i][k] & rw;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        tw  = '0;
        zw  = '0;
        nst = '0;
        for (int i = 0; i < d; i++) begin
            for (int k = 0; k < 5; k++) begin
                for (int j = 0; j < d; j++) begin
                    tw[i][k] = tw[i][k] ^ u_q[i][j][k] ^ (aw[i][k] & s_q[i][j][k]);
                end
            end
        end
        for (int s = 0; s < d; s++) begin
            for (int k = 0; k < 5; k++) begin
                zw[s][k] = yw[s][k] ^ tw[s][(k+1)%5];
            end
            zw[s][1] = zw[s][1] ^ zw[s][0];
            zw[s][0] = zw[s][0] ^ zw[s][4];
            zw[s][3] = zw[s][3] ^ zw[s][2];
            if (s == 0) begin
                zw[s][2] = ~zw[s][2];
            end
            for (int k = 0; k < 5; k++) begin
                nst[s][(4-k)*64 +: 64] = diffuse(zw[s][k], k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int j = 0; j < 320; j++) begin
                        for (int s = 0; s < d; s++) begin
                            st_d[s][j] = in[d*j+s];
                        end
                    end
                    case (round_sel)
                        2'd1:    idx_d = 4'd4;
                        2'd2:    idx_d = 4'd6;
                        default: idx_d = 4'd0;
                    endcase
                    state_d = RA;
                end
            end
            RA: begin
                if (rnd_valid) begin
                    state_d = RB;
                end
            end
            RB: begin
                st_d    = nst;
                idx_d   = idx_q + 4'd1;
                state_d = (idx_q == 4'd11) ? DONE : RA;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            st_q        <= '0;
            idx_q       <= '0;
            s_q         <= '0;
            u_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            idx_q       <= idx_d;
            s_q         <= s_d;
            u_q         <= u_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

    // Intermediate round states never leave the core
    always_comb begin
        out = '0;
        for (int j = 0; j < 320; j++) begin
            for (int s = 0; s < d; s++) begin
                out[d*j+s] = st_q[s][j] & out_valid_q;
            end
        end
    end

endmodule

// File: tb/tb_ascon_perm_msk.sv
// tb_ascon_perm_msk: directed tests of the masked Ascon permutation core
// against an unmasked 64-bit-word reference permutation.
module tb_ascon_perm_msk;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         in_valid, in_ready, rnd_valid, out_valid, out_ready, busy;
    logic [1:0]   round_sel;
    logic [639:0] in2, out2;
    logic [319:0] rnd2;

    logic         in_valid3, in_ready3, rnd_valid3, out_valid3, out_ready3, busy3;
    logic [1:0]   round_sel3;
    logic [959:0] in3, out3, rnd3;

    int errors = 0;
    int checks = 0;

    localparam logic [319:0] GOLD_IN = {
        64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
        64'h0001020304050607, 64'h08090a0b0c0d0e0f};

    logic [319:0] ref12, ref8, ref6;

    ascon_perm_msk #(.d(2)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .round_sel(round_sel), .in(in2), .rnd(rnd2), .rnd_valid(rnd_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out(out2), .busy(busy));

    ascon_perm_msk #(.d(3)) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
        .round_sel(round_sel3), .in(in3), .rnd(rnd3), .rnd_valid(rnd_valid3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out(out3), .busy(busy3));

    function automatic logic [63:0] rr(input logic [63:0] w, input int n);
        logic [127:0] t;
        t = {w, w} >> n;
        return t[63:0];
    endfunction

    function automatic logic [319:0] ascon_ref(input logic [319:0] s, input int nr);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        for (int i = 12 - nr; i < 12; i++) begin
            x2 = x2 ^ {56'd0, 4'(15 - i), 4'(i)};
            x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3;
            t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
            x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
            x0 = x0 ^ rr(x0, 19) ^ rr(x0, 28);
            x1 = x1 ^ rr(x1, 61) ^ rr(x1, 39);
            x2 = x2 ^ rr(x2, 1) ^ rr(x2, 6);
            x3 = x3 ^ rr(x3, 10) ^ rr(x3, 17);
            x4 = x4 ^ rr(x4, 7) ^ rr(x4, 41);
        end
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [959:0] rand960();
        logic [959:0] v;
        for (int i = 0; i < 30; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [639:0] share2(input logic [319:0] s, input logic [319:0] m);
        logic [639:0] v;
        for (int j = 0; j < 320; j++) begin
            v[2*j]   = s[j] ^ m[j];
            v[2*j+1] = m[j];
        end
        return v;
    endfunction

    function automatic logic [319:0] comb2(input logic [639:0] o);
        logic [319:0] v;
        for (int j = 0; j < 320; j++) v[j] = o[2*j] ^ o[2*j+1];
        return v;
    endfunction

    function automatic logic [959:0] share3(input logic [319:0] s,
                                            input logic [319:0] m1, input logic [319:0] m2);
        logic [959:0] v;
        for (int j = 0; j < 320; j++) begin
            v[3*j]   = s[j] ^ m1[j] ^ m2[j];
            v[3*j+1] = m1[j];
            v[3*j+2] = m2[j];
        end
        return v;
    endfunction

    function automatic logic [319:0] comb3(input logic [959:0] o);
        logic [319:0] v;
        for (int j = 0; j < 320; j++) v[j] = o[3*j] ^ o[3*j+1] ^ o[3*j+2];
        return v;
    endfunction

    // Stimulus driver for the d=2 core; latency counted in edges after accept
    task automatic run2(input logic [319:0] st, input logic [1:0] rs,
                        input logic [319:0] m, input bit rnd_rand,
                        input int stall_at, input int stall_n, input bit release_out,
                        output int lat, output logic [319:0] res, output bit to);
        @(negedge clk);
        in_valid  = 1'b1;
        in2       = share2(st, m);
        round_sel = rs;
        rnd_valid = 1'b1;
        rnd2      = rnd_rand ? rand320() : '1;
        @(posedge clk);
        lat = 0;
        to  = 1'b0;
        forever begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) break;
            if (lat > 100) begin
                to = 1'b1;
                break;
            end
            rnd_valid = !(stall_at >= 0 && lat >= stall_at && lat < stall_at + stall_n);
            if (rnd_rand) rnd2 = rand320();
            @(posedge clk);
            lat++;
        end
        res = comb2(out2);
        rnd_valid = 1'b1;
        if (release_out && !to) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (out2 !== '0) begin
            errors++; $display("FAIL reset_out: got %h want 0", out2);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if (in_ready3 !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready_d3: got %b want 1", in_ready3);
        end
    endtask

    task automatic test_golden();
        int lat;
        logic [319:0] res;
        bit to;
        run2(GOLD_IN, 2'd0, '0, 1'b0, -1, 0, 1'b1, lat, res, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL golden_timeout: got timeout want out_valid");
        end
        checks++;
        if (lat !== 24) begin
            errors++; $display("FAIL golden_latency: got %0d want 24", lat);
        end
        checks++;
        if (res !== ref12) begin
            errors++; $display("FAIL golden_value: got %h want %h", res, ref12);
        end
    endtask

    task automatic test_rounds();
        int lat;
        logic [319:0] res;
        bit to;
        logic [1:0] rs_tab [3];
        int lat_tab [3];
        logic [319:0] exp_tab [3];
        rs_tab  = '{2'd1, 2'd2, 2'd3};
        lat_tab = '{16, 12, 24};
        exp_tab = '{ref8, ref6, ref12};
        for (int i = 0; i < 3; i++) begin
            run2(GOLD_IN, rs_tab[i], '0, 1'b0, -1, 0, 1'b1, lat, res, to);
            checks++;
            if (to || lat !== lat_tab[i]) begin
                errors++;
                $display("FAIL rounds_latency sel=%0d: got %0d want %0d", rs_tab[i], lat, lat_tab[i]);
            end
            checks++;
            if (res !== exp_tab[i]) begin
                errors++;
                $display("FAIL rounds_value sel=%0d: got %h want %h", rs_tab[i], res, exp_tab[i]);
            end
        end
    endtask

    task automatic test_masking();
        int lat;
        logic [319:0] res;
        bit to;
        int cnt;
        for (int i = 0; i < 2; i++) begin
            run2(GOLD_IN, 2'd0, rand320(), 1'b1, -1, 0, 1'b1, lat, res, to);
            checks++;
            if (to || res !== ref12) begin
                errors++; $display("FAIL mask_d2 run %0d: got %h want %h", i, res, ref12);
            end
        end
        @(negedge clk);
        in_valid3 = 1'b1;
        in3       = share3(GOLD_IN, rand320(), rand320());
        rnd3      = rand960();
        @(posedge clk);
        cnt = 0;
        @(negedge clk);
        in_valid3 = 1'b0;
        while (!out_valid3 && cnt < 100) begin
            rnd3 = rand960();
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 24) begin
            errors++; $display("FAIL mask_d3_latency: got %0d want 24", cnt);
        end
        checks++;
        if (comb3(out3) !== ref12) begin
            errors++; $display("FAIL mask_d3_value: got %h want %h", comb3(out3), ref12);
        end
        out_ready3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready3 = 1'b0;
    endtask

    task automatic test_stall();
        int lat;
        logic [319:0] res;
        bit to;
        run2(GOLD_IN, 2'd0, rand320(), 1'b1, 8, 3, 1'b1, lat, res, to);
        checks++;
        if (to || lat !== 27) begin
            errors++; $display("FAIL stall_latency: got %0d want 27", lat);
        end
        checks++;
        if (res !== ref12) begin
            errors++; $display("FAIL stall_value: got %h want %h", res, ref12);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [319:0] res;
        bit to;
        logic [639:0] hold;
        int cnt;
        run2(GOLD_IN, 2'd0, '0, 1'b0, -1, 0, 1'b0, lat, res, to);
        checks++;
        if (to || res !== ref12) begin
            errors++; $display("FAIL bp_first_value: got %h want %h", res, ref12);
        end
        hold      = out2;
        in_valid  = 1'b1;
        in2       = share2(GOLD_IN, rand320());
        round_sel = 2'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out2 !== hold || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got valid=%b ready=%b same=%b want 1 0 1",
                         i, out_valid, in_ready, out2 === hold);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: got ready=%b valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accept: got busy=%b ready=%b want 1 0", busy, in_ready);
        end
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 16 || comb2(out2) !== ref8) begin
            errors++;
            $display("FAIL bp_second: got lat=%0d val=%h want 16 %h", cnt, comb2(out2), ref8);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [319:0] res;
        bit to;
        @(negedge clk);
        in_valid  = 1'b1;
        in2       = share2(GOLD_IN, '0);
        round_sel = 2'd0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out2 !== '0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b busy=%b out_zero=%b want 0 0 1",
                     out_valid, busy, out2 === '0);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_release_ready: got %b want 1", in_ready);
        end
        run2(GOLD_IN, 2'd0, '0, 1'b0, -1, 0, 1'b1, lat, res, to);
        checks++;
        if (to || lat !== 24 || res !== ref12) begin
            errors++; $display("FAIL mid_rerun: got lat=%0d val=%h want 24 %h", lat, res, ref12);
        end
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        round_sel  = 2'd0;
        in2        = '0;
        rnd2       = '1;
        rnd_valid  = 1'b1;
        out_ready  = 1'b0;
        in_valid3  = 1'b0;
        round_sel3 = 2'd0;
        in3        = '0;
        rnd3       = '0;
        rnd_valid3 = 1'b1;
        out_ready3 = 1'b0;
        ref12 = ascon_ref(GOLD_IN, 12);
        ref8  = ascon_ref(GOLD_IN, 8);
        ref6  = ascon_ref(GOLD_IN, 6);
        test_reset();
        test_golden();
        test_rounds();
        test_masking();
        test_stall();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
